mp_alu_seq: RTL

Multi-precision sequencer for the 16-bit ALU. Accepts one operation on operands up to 16×WORDS bits, drives the ALU one 16-bit word per cycle from least significant upward, and chains each word's carry_out into the next word's carry_in. Collects the result words, the final carry and an all-words-equal flag, then returns them on a valid/ready response port. Sits directly upstream of the ALU, feeding its operand, select and mode ports, and directly downstream of it, consuming alu_out, carry_out and compare.

---
 rtl/mp_alu_pkg.sv | 21 ++
 rtl/mp_alu_seq.sv | 137 +++++++++++++
 2 files changed

// File: rtl/mp_alu_pkg.sv
// Shared definitions for the multi-precision ALU sequencer and its clients:
// word width, sequencer states and the select/mode pairs clients issue.
package mp_alu_pkg;

  localparam int WORD_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Each select code is only meaningful together with the mode beside it.
  localparam logic [3:0] SEL_XOR_L  = 4'b0110;
  localparam logic       MODE_XOR_L = 1'b0;
  localparam logic [3:0] SEL_ADD_A  = 4'b1001;
  localparam logic       MODE_ADD_A = 1'b1;
  localparam logic [3:0] SEL_SUB_A  = 4'b0110;
  localparam logic       MODE_SUB_A = 1'b1;

endpackage

// File: rtl/mp_alu_seq.sv
// Multi-precision sequencer: feeds a 16-bit ALU one word per cycle, LSW first,
// chaining carries, and returns the assembled result on a valid/ready port.
module mp_alu_seq
  import mp_alu_pkg::*;
#(
  parameter int WORDS = 4,
  parameter int LW    = (WORDS > 1) ? $clog2(WORDS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [WORD_W*WORDS-1:0]   req_a,
  input  logic [WORD_W*WORDS-1:0]   req_b,
  input  logic [LW-1:0]             req_len,
  input  logic [3:0]                req_select,
  input  logic                      req_mode,
  input  logic                      req_carry_in,
  output logic [WORD_W-1:0]         alu_in_a,
  output logic [WORD_W-1:0]         alu_in_b,
  output logic [3:0]                alu_select,
  output logic                      alu_mode,
  output logic                      alu_carry_in,
  input  logic [WORD_W-1:0]         alu_out,
  input  logic                      alu_carry_out,
  input  logic                      alu_compare,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [WORD_W*WORDS-1:0]   rsp_result,
  output logic                      rsp_carry,
  output logic                      rsp_equal
);

  state_t              state, state_n;
  logic [WORD_W-1:0]   req_a_w [WORDS];
  logic [WORD_W-1:0]   req_b_w [WORDS];
  logic [WORD_W-1:0]   a_q     [WORDS];
  logic [WORD_W-1:0]   b_q     [WORDS];
  logic [WORD_W-1:0]   res_q   [WORDS];
  logic [3:0]          sel_q;
  logic                mode_q;
  logic                cin_q;
  logic [LW-1:0]       len_q;
  logic [LW-1:0]       idx;
  logic                carry_q;
  logic                eq_q;
  logic                accept;
  logic                last;

  for (genvar k = 0; k < WORDS; k++) begin : g_words
    assign req_a_w[k]                      = req_a[k*WORD_W +: WORD_W];
    assign req_b_w[k]                      = req_b[k*WORD_W +: WORD_W];
    assign rsp_result[k*WORD_W +: WORD_W]  = res_q[k];
  end

  assign accept    = req_valid && req_ready;
  assign last      = (idx == len_q);
  assign rsp_carry = carry_q;
  assign rsp_equal = eq_q;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // NOTE: every output gets a default before the case so no path can infer a latch.
  always_comb begin
    state_n      = state;
    req_ready    = 1'b0;
    rsp_valid    = 1'b0;
    alu_in_a     = '0;
    alu_in_b     = '0;
    alu_select   = '0;
    alu_mode     = 1'b0;
    alu_carry_in = 1'b0;
    case (state)
      IDLE: begin
        req_ready = !rst;
        if (req_valid) state_n = RUN;
      end
      RUN: begin
        alu_in_a     = a_q[idx];
        alu_in_b     = b_q[idx];
        alu_select   = sel_q;
        alu_mode     = mode_q;
        // Logic ops never see a carry; arithmetic seeds word 0 from the request.
        alu_carry_in = mode_q && ((idx == '0) ? cin_q : carry_q);
        if (last) state_n = DONE;
      end
      DONE: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // NOTE: operand registers carry no reset; they are always written before use.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q    <= req_a_w;
      b_q    <= req_b_w;
      sel_q  <= req_select;
      mode_q <= req_mode;
      cin_q  <= req_carry_in;
      len_q  <= (int'(req_len) > WORDS - 1) ? LW'(WORDS - 1) : req_len;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_q   <= '{default: '0};
      carry_q <= 1'b0;
      eq_q    <= 1'b0;
      idx     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            res_q   <= '{default: '0};
            carry_q <= 1'b0;
            eq_q    <= 1'b1;
            idx     <= '0;
          end
        end
        RUN: begin
          res_q[idx] <= alu_out;
          carry_q    <= alu_carry_out;
          eq_q       <= eq_q && alu_compare;
          if (!last) idx <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
